// File: rtl/rdma_rx_arbiter.sv
// Purpose     : packet-atomic 2:1 AXI-Stream arbiter feeding one RX consumer.
// Latency     : zero-cycle data path while granted; one IDLE bubble cycle between packets.
// Backpressure: M_AXIS_TREADY passes straight to the granted source; the other source sees TREADY=0.
//
// Ports
//   clk, reset                          clock, synchronous active-high reset
//   S0_AXIS_{TDATA,TVALID,TLAST,TREADY} upstream source 0
//   S1_AXIS_{TDATA,TVALID,TLAST,TREADY} upstream source 1
//   M_AXIS_{TDATA,TVALID,TLAST,TREADY}  downstream consumer (packet/cycle-ID extractor)
//   grant                               current / most recent winner (0 = S0, 1 = S1)
//   busy                                high while a packet is being forwarded
//   s0_pkt_count, s1_pkt_count          forwarded packet counters
//
// Optional feature macro: ARB_STATS_EN
//   defined   -> per-source packet counters, incremented on every forwarded TLAST beat,
//                wrapping at 2^CNTW, cleared only by reset
//   undefined -> counter logic omitted, s0_pkt_count / s1_pkt_count tied to zero
//
// Parameters
//   DW         TDATA width
//   CNTW       packet counter width
//   FIXED_PRIO 0 = round-robin between the sources, 1 = S0 always wins a tie

module rdma_rx_arbiter #(
    parameter int DW         = 512,
    parameter int CNTW       = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic            clk,
    input  logic            reset,

    input  logic [DW-1:0]   S0_AXIS_TDATA,
    input  logic            S0_AXIS_TVALID,
    input  logic            S0_AXIS_TLAST,
    output logic            S0_AXIS_TREADY,

    input  logic [DW-1:0]   S1_AXIS_TDATA,
    input  logic            S1_AXIS_TVALID,
    input  logic            S1_AXIS_TLAST,
    output logic            S1_AXIS_TREADY,

    output logic [DW-1:0]   M_AXIS_TDATA,
    output logic            M_AXIS_TVALID,
    output logic            M_AXIS_TLAST,
    input  logic            M_AXIS_TREADY,

    output logic            grant,
    output logic            busy,
    output logic [CNTW-1:0] s0_pkt_count,
    output logic [CNTW-1:0] s1_pkt_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0] state;
    logic       grant_q;
    logic       busy_q;
    logic       last_grant_q;   // winner of the previous packet, drives round-robin tie-break
    logic       winner;
    logic       any_req;
    logic       beat;
    logic       eop;

    // ------------------------------------------------------------------
    // Arbitration: a lone requester wins outright; on a tie the source
    // that did not win last time goes next (or S0 when priority is fixed).
    // ------------------------------------------------------------------
    assign any_req = S0_AXIS_TVALID | S1_AXIS_TVALID;

    always_comb begin
        winner = 1'b0;
        if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else if (S1_AXIS_TVALID) begin
            winner = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Data path: pure combinational mux while in XFER. In IDLE the master
    // side is quiet and both sources are held off, so nothing can slip
    // through during the arbitration bubble.
    // ------------------------------------------------------------------
    always_comb begin
        M_AXIS_TDATA   = '0;
        M_AXIS_TVALID  = 1'b0;
        M_AXIS_TLAST   = 1'b0;
        S0_AXIS_TREADY = 1'b0;
        S1_AXIS_TREADY = 1'b0;
        if (state == ST_XFER) begin
            if (grant_q) begin
                M_AXIS_TDATA   = S1_AXIS_TDATA;
                M_AXIS_TVALID  = S1_AXIS_TVALID;
                M_AXIS_TLAST   = S1_AXIS_TLAST;
                S1_AXIS_TREADY = M_AXIS_TREADY;
            end else begin
                M_AXIS_TDATA   = S0_AXIS_TDATA;
                M_AXIS_TVALID  = S0_AXIS_TVALID;
                M_AXIS_TLAST   = S0_AXIS_TLAST;
                S0_AXIS_TREADY = M_AXIS_TREADY;
            end
        end
    end

    // A beat is a handshake on the granted source, which is the same as a
    // handshake on the master port because the mux is transparent.
    assign beat = M_AXIS_TVALID & M_AXIS_TREADY;
    assign eop  = beat & M_AXIS_TLAST;

    // ------------------------------------------------------------------
    // Control FSM. The grant is only re-evaluated in IDLE, so a granted
    // source that stalls mid-packet keeps the consumer for as long as it
    // takes; there is deliberately no timeout.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            last_grant_q <= 1'b1;   // makes S0 the first winner of an initial tie
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q <= winner;
                        busy_q  <= 1'b1;
                        state   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (eop) begin
                        last_grant_q <= grant_q;
                        busy_q       <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

    // ------------------------------------------------------------------
    // Optional per-source packet statistics.
    // ------------------------------------------------------------------
`ifdef ARB_STATS_EN
    logic [CNTW-1:0] s0_cnt_q;
    logic [CNTW-1:0] s1_cnt_q;

    // Counters wrap naturally at 2^CNTW; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_cnt_q <= '0;
            s1_cnt_q <= '0;
        end else if (eop) begin
            if (grant_q) begin
                s1_cnt_q <= s1_cnt_q + CNTW'(1);
            end else begin
                s0_cnt_q <= s0_cnt_q + CNTW'(1);
            end
        end
    end

    assign s0_pkt_count = s0_cnt_q;
    assign s1_pkt_count = s1_cnt_q;
`else
    assign s0_pkt_count = '0;
    assign s1_pkt_count = '0;
`endif

endmodule

// File: tb/tb_rdma_rx_arbiter.sv
// Purpose     : self-checking bench for rdma_rx_arbiter (round-robin and fixed-priority builds).
// Latency     : checks zero-cycle forwarding and the single IDLE bubble between packets.
// Backpressure: drives M_AXIS_TREADY patterns and source stalls, checks TREADY routing.

module tb_rdma_rx_arbiter;

    localparam int DW   = 512;
    localparam int CNTW = 32;
`ifdef ARB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [DW-1:0]   sdat [2];
    logic            svld [2];
    logic            slast[2];
    logic            m_rdy;

    logic [DW-1:0]   m_dat, f_m_dat;
    logic            m_vld, m_last, s0_rdy, s1_rdy, grant, busy;
    logic            f_m_vld, f_m_last, f_s0_rdy, f_s1_rdy, f_grant, f_busy;
    logic [CNTW-1:0] c0, c1, f_c0, f_c1;

    rdma_rx_arbiter #(.DW(DW), .CNTW(CNTW), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .S0_AXIS_TDATA(sdat[0]), .S0_AXIS_TVALID(svld[0]), .S0_AXIS_TLAST(slast[0]), .S0_AXIS_TREADY(s0_rdy),
        .S1_AXIS_TDATA(sdat[1]), .S1_AXIS_TVALID(svld[1]), .S1_AXIS_TLAST(slast[1]), .S1_AXIS_TREADY(s1_rdy),
        .M_AXIS_TDATA(m_dat), .M_AXIS_TVALID(m_vld), .M_AXIS_TLAST(m_last), .M_AXIS_TREADY(m_rdy),
        .grant(grant), .busy(busy), .s0_pkt_count(c0), .s1_pkt_count(c1)
    );

    rdma_rx_arbiter #(.DW(DW), .CNTW(CNTW), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset),
        .S0_AXIS_TDATA(sdat[0]), .S0_AXIS_TVALID(svld[0]), .S0_AXIS_TLAST(slast[0]), .S0_AXIS_TREADY(f_s0_rdy),
        .S1_AXIS_TDATA(sdat[1]), .S1_AXIS_TVALID(svld[1]), .S1_AXIS_TLAST(slast[1]), .S1_AXIS_TREADY(f_s1_rdy),
        .M_AXIS_TDATA(f_m_dat), .M_AXIS_TVALID(f_m_vld), .M_AXIS_TLAST(f_m_last), .M_AXIS_TREADY(m_rdy),
        .grant(f_grant), .busy(f_busy), .s0_pkt_count(f_c0), .s1_pkt_count(f_c1)
    );

    int checks   = 0;
    int failures = 0;

    // Source engine state: each source emits npk packets of plen beats.
    bit use_fp;
    bit act[2], hold[2], rand_len;
    int npk[2], plen[2], beat[2], pid[2];

    // Outputs sampled at the falling edge of the selected DUT.
    logic [DW-1:0]   o_dat;
    logic            o_vld, o_last, o_grant, o_busy;
    logic            o_rdy[2];
    logic [CNTW-1:0] o_c0, o_c1;

    function automatic logic [DW-1:0] mkdat(input int s, input int p, input int b);
        logic [31:0] v;
        v = 32'h1000_0000 + 32'(s << 24) + 32'(p << 8) + 32'(b);
        mkdat = '0;
        mkdat[31:0] = v;
    endfunction

    task automatic drive();
        for (int s = 0; s < 2; s++) begin
            svld[s]  = act[s] & ~hold[s];
            sdat[s]  = mkdat(s, pid[s], beat[s]);
            slast[s] = (beat[s] == plen[s] - 1);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        if (use_fp) begin
            o_dat = f_m_dat; o_vld = f_m_vld; o_last = f_m_last; o_grant = f_grant; o_busy = f_busy;
            o_rdy[0] = f_s0_rdy; o_rdy[1] = f_s1_rdy; o_c0 = f_c0; o_c1 = f_c1;
        end else begin
            o_dat = m_dat; o_vld = m_vld; o_last = m_last; o_grant = grant; o_busy = busy;
            o_rdy[0] = s0_rdy; o_rdy[1] = s1_rdy; o_c0 = c0; o_c1 = c1;
        end
    endtask

    // Move across the rising edge and let each source react to its handshake.
    task automatic advance();
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            if (svld[s] && o_rdy[s]) begin
                if (slast[s]) begin
                    pid[s]++;
                    npk[s]--;
                    beat[s] = 0;
                    if (npk[s] == 0) act[s] = 0;
                    else if (rand_len) plen[s] = $urandom_range(1, 4);
                end else begin
                    beat[s]++;
                end
            end
        end
        drive();
    endtask

    task automatic start_pkts(input int s, input int n, input int len);
        act[s] = 1; npk[s] = n; plen[s] = len; beat[s] = 0; hold[s] = 0;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1; m_rdy = 1'b0; rand_len = 0;
        for (int s = 0; s < 2; s++) begin
            act[s] = 0; hold[s] = 0; npk[s] = 0; plen[s] = 1; beat[s] = 0; pid[s] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        sample();
        checks++;
        if (o_busy !== 1'b0 || o_grant !== 1'b0 || o_vld !== 1'b0 || o_dat !== '0 || o_last !== 1'b0)
            begin failures++; $display("FAIL reset_state busy=%b grant=%b vld=%b last=%b exp all 0", o_busy, o_grant, o_vld, o_last); end
        checks++;
        if (o_rdy[0] !== 1'b0 || o_rdy[1] !== 1'b0)
            begin failures++; $display("FAIL reset_ready rdy0=%b rdy1=%b exp 0 0", o_rdy[0], o_rdy[1]); end
        checks++;
        if (o_c0 !== '0 || o_c1 !== '0)
            begin failures++; $display("FAIL reset_counts c0=%0d c1=%0d exp 0 0", o_c0, o_c1); end
        advance();
    endtask

    task automatic test_single_s0();
        int busy_cycles;
        busy_cycles = 0;
        do_reset();
        m_rdy = 1'b1;
        start_pkts(0, 1, 3);
        sample();
        checks++;
        if (o_busy !== 1'b0 || o_vld !== 1'b0 || o_rdy[0] !== 1'b0)
            begin failures++; $display("FAIL single_bubble busy=%b vld=%b rdy0=%b exp 0 0 0", o_busy, o_vld, o_rdy[0]); end
        advance();
        for (int k = 0; k < 3; k++) begin
            sample();
            if (o_busy === 1'b1) busy_cycles++;
            checks++;
            if (o_vld !== 1'b1 || o_rdy[0] !== 1'b1 || o_grant !== 1'b0 || o_dat !== mkdat(0, 0, k) || o_last !== (k == 2))
                begin failures++; $display("FAIL single_beat%0d vld=%b rdy0=%b grant=%b dat=%h last=%b exp 1 1 0 %h %b",
                      k, o_vld, o_rdy[0], o_grant, o_dat[31:0], o_last, 32'h1000_0000 + 32'(k), (k == 2)); end
            advance();
        end
        sample();
        checks++;
        if (o_busy !== 1'b0 || o_vld !== 1'b0 || o_grant !== 1'b0)
            begin failures++; $display("FAIL single_after busy=%b vld=%b grant=%b exp 0 0 0", o_busy, o_vld, o_grant); end
        checks++;
        if (busy_cycles != 3)
            begin failures++; $display("FAIL single_busy_cycles got=%0d exp=3", busy_cycles); end
        checks++;
        if (o_c0 !== CNTW'(STATS) || o_c1 !== '0)
            begin failures++; $display("FAIL single_counts c0=%0d c1=%0d exp %0d 0", o_c0, o_c1, STATS); end
        advance();
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] expq[$];
        int n, cyc;
        do_reset();
        m_rdy = 1'b1;
        for (int i = 0; i < 4; i++)
            for (int s = 0; s < 2; s++)
                for (int b = 0; b < 2; b++) expq.push_back(mkdat(s, i, b));
        start_pkts(0, 4, 2);
        start_pkts(1, 4, 2);
        n = 0;
        for (cyc = 0; cyc < 40 && n < 16; cyc++) begin
            sample();
            checks++;
            if (o_rdy[0] === 1'b1 && o_rdy[1] === 1'b1)
                begin failures++; $display("FAIL rr_both_ready cyc=%0d", cyc); end
            if (o_vld === 1'b1 && m_rdy) begin
                checks++;
                if (o_dat !== expq[n])
                    begin failures++; $display("FAIL rr_beat%0d got=%h exp=%h", n, o_dat[31:0], expq[n][31:0]); end
                n++;
            end
            advance();
        end
        checks++;
        if (n != 16 || cyc != 24)
            begin failures++; $display("FAIL rr_timing beats=%0d cycles=%0d exp 16 24", n, cyc); end
    endtask

    task automatic test_fixed_prio();
        use_fp = 1;
        do_reset();
        m_rdy = 1'b1;
        start_pkts(0, 4, 2);
        start_pkts(1, 50, 2);
        for (int cyc = 0; cyc < 12; cyc++) begin
            sample();
            checks++;
            if (o_rdy[1] !== 1'b0 || (o_busy === 1'b1 && o_grant !== 1'b0))
                begin failures++; $display("FAIL fp_s1_served cyc=%0d rdy1=%b grant=%b exp 0 0", cyc, o_rdy[1], o_grant); end
            advance();
        end
        checks++;
        if (npk[0] != 0 || beat[1] != 0 || pid[1] != 0)
            begin failures++; $display("FAIL fp_progress s0_left=%0d s1_beats=%0d exp 0 0", npk[0], beat[1] + pid[1]); end
        act[0] = 0; act[1] = 0;
        drive();
        use_fp = 0;
    endtask

    task automatic test_stall_grant();
        logic [DW-1:0] expq[$];
        int n;
        do_reset();
        m_rdy = 1'b1;
        start_pkts(1, 1, 4);
        sample();
        advance();
        start_pkts(0, 1, 2);
        for (int k = 0; k < 2; k++) begin
            sample();
            checks++;
            if (o_grant !== 1'b1 || o_rdy[0] !== 1'b0 || o_vld !== 1'b1 || o_dat !== mkdat(1, 0, k))
                begin failures++; $display("FAIL stall_pre%0d grant=%b rdy0=%b vld=%b dat=%h", k, o_grant, o_rdy[0], o_vld, o_dat[31:0]); end
            if (k == 1) hold[1] = 1;
            advance();
        end
        for (int k = 0; k < 5; k++) begin
            sample();
            checks++;
            if (o_grant !== 1'b1 || o_busy !== 1'b1 || o_rdy[0] !== 1'b0 || o_vld !== 1'b0)
                begin failures++; $display("FAIL stall_hold%0d grant=%b busy=%b rdy0=%b vld=%b exp 1 1 0 0", k, o_grant, o_busy, o_rdy[0], o_vld); end
            advance();
        end
        hold[1] = 0;
        drive();
        expq = '{mkdat(1, 0, 2), mkdat(1, 0, 3), mkdat(0, 0, 0), mkdat(0, 0, 1)};
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            sample();
            if (o_vld === 1'b1 && m_rdy) begin
                checks++;
                if (o_dat !== expq[n])
                    begin failures++; $display("FAIL stall_resume%0d got=%h exp=%h", n, o_dat[31:0], expq[n][31:0]); end
                n++;
            end
            advance();
        end
        checks++;
        if (n != 4)
            begin failures++; $display("FAIL stall_resume_count got=%0d exp=4", n); end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        start_pkts(0, 1, 4);
        n = 0;
        for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
            m_rdy = (cyc % 2 == 1);
            sample();
            if (o_vld === 1'b1 && m_rdy) begin
                checks++;
                if (o_dat[31:0] !== 32'h1000_0000 + 32'(n))
                    begin failures++; $display("FAIL bp_beat%0d got=%h exp=%h", n, o_dat[31:0], 32'h1000_0000 + 32'(n)); end
                n++;
            end
            advance();
        end
        m_rdy = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            sample();
            if (o_vld === 1'b1) n++;
            advance();
        end
        checks++;
        if (n != 4)
            begin failures++; $display("FAIL bp_beat_count got=%0d exp=4", n); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        m_rdy = 1'b1;
        start_pkts(0, 2, 4);
        // bubble, 4 beats, bubble, beat 0 of the second packet
        repeat (7) begin
            sample();
            advance();
        end
        reset = 1'b1;
        sample();
        checks++;
        if (o_busy !== 1'b1 || o_dat !== mkdat(0, 1, 1) || o_c0 !== CNTW'(STATS))
            begin failures++; $display("FAIL rstmid_pre busy=%b dat=%h c0=%0d exp 1 %h %0d", o_busy, o_dat[31:0], mkdat(0, 1, 1), o_c0, STATS); end
        advance();
        reset = 1'b0;
        act[0] = 0;
        start_pkts(1, 1, 2);
        sample();
        checks++;
        if (o_busy !== 1'b0 || o_vld !== 1'b0 || o_rdy[0] !== 1'b0 || o_rdy[1] !== 1'b0 || o_grant !== 1'b0)
            begin failures++; $display("FAIL rstmid_post busy=%b vld=%b rdy0=%b rdy1=%b grant=%b exp all 0", o_busy, o_vld, o_rdy[0], o_rdy[1], o_grant); end
        checks++;
        if (o_c0 !== '0 || o_c1 !== '0)
            begin failures++; $display("FAIL rstmid_counts c0=%0d c1=%0d exp 0 0", o_c0, o_c1); end
        advance();
        n = 0;
        for (int cyc = 0; cyc < 10 && n < 2; cyc++) begin
            sample();
            if (o_vld === 1'b1 && m_rdy) begin
                checks++;
                if (o_dat !== mkdat(1, 0, n) || o_grant !== 1'b1)
                    begin failures++; $display("FAIL rstmid_s1_beat%0d got=%h grant=%b exp=%h 1", n, o_dat[31:0], o_grant, mkdat(1, 0, n)); end
                n++;
            end
            advance();
        end
        checks++;
        if (n != 2)
            begin failures++; $display("FAIL rstmid_s1_count got=%0d exp=2", n); end
    endtask

    // Randomized traffic against a packet-ownership model: whoever owns the
    // consumer sees it transparently, nobody owns it for one cycle between
    // packets, and ties go to the source that did not win last.
    task automatic test_random_model();
        int owner, lastw, win;
        int done[2];
        logic eg, ev, el, eb, er0, er1;
        logic [DW-1:0] ed;
        do_reset();
        rand_len = 1;
        start_pkts(0, $urandom_range(5, 12), $urandom_range(1, 4));
        start_pkts(1, $urandom_range(5, 12), $urandom_range(1, 4));
        owner = -1; lastw = 1; eg = 1'b0; done[0] = 0; done[1] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!act[0] && !act[1] && owner < 0) break;
            m_rdy = ($urandom_range(0, 3) != 0);
            sample();
            eb = (owner >= 0);
            if (owner >= 0) begin
                ev = svld[owner]; el = slast[owner]; ed = sdat[owner];
                er0 = (owner == 0) && m_rdy; er1 = (owner == 1) && m_rdy;
            end else begin
                ev = 1'b0; el = 1'b0; ed = '0; er0 = 1'b0; er1 = 1'b0;
            end
            checks++;
            if (o_vld !== ev || o_last !== el || o_dat !== ed)
                begin failures++; $display("FAIL rnd_mout cyc=%0d vld=%b last=%b dat=%h exp %b %b %h", cyc, o_vld, o_last, o_dat[31:0], ev, el, ed[31:0]); end
            checks++;
            if (o_rdy[0] !== er0 || o_rdy[1] !== er1)
                begin failures++; $display("FAIL rnd_ready cyc=%0d rdy=%b%b exp %b%b", cyc, o_rdy[0], o_rdy[1], er0, er1); end
            checks++;
            if (o_busy !== eb || o_grant !== eg)
                begin failures++; $display("FAIL rnd_state cyc=%0d busy=%b grant=%b exp %b %b", cyc, o_busy, o_grant, eb, eg); end
            if (owner < 0) begin
                if (svld[0] || svld[1]) begin
                    win   = (svld[0] && svld[1]) ? 1 - lastw : (svld[0] ? 0 : 1);
                    owner = win;
                    eg    = (win == 1);
                end
            end else if (svld[owner] && m_rdy && slast[owner]) begin
                lastw = owner;
                done[owner]++;
                owner = -1;
            end
            for (int s = 0; s < 2; s++)
                if (!svld[s] || o_rdy[s]) hold[s] = ($urandom_range(0, 4) == 0);
            advance();
        end
        checks++;
        if (act[0] || act[1])
            begin failures++; $display("FAIL rnd_timeout s0_left=%0d s1_left=%0d exp 0 0", npk[0], npk[1]); end
        sample();
        checks++;
        if (o_c0 !== CNTW'(STATS * done[0]) || o_c1 !== CNTW'(STATS * done[1]))
            begin failures++; $display("FAIL rnd_counts c0=%0d c1=%0d exp %0d %0d", o_c0, o_c1, STATS * done[0], STATS * done[1]); end
        advance();
    endtask

    initial begin
        use_fp = 0;
        test_reset();
        test_single_s0();
        test_round_robin();
        test_fixed_prio();
        test_stall_grant();
        test_backpressure();
        test_reset_mid();
        for (int r = 0; r < 3; r++) test_random_model();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
